ch3_wave_sequencer: RTL and testbench

// Playback controller for channel 3: owns the wave RAM port, steps a 5-bit nibble index at
// (2048-freq) ticks of the 2 MHz enable, fetches bytes and drives the 4-bit play sample.

---
 rtl/ch3_wave_sequencer.sv | 153 +++++++++++++++
 tb/tb_ch3_wave_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ch3_wave_sequencer.sv
// Channel-3 wave playback sequencer: steps the nibble index, fetches wave RAM, arbitrates CPU FF3x access.
// CPU ack one cycle after each request; playback fetch always wins the RAM port. Option: CH3_LENGTH_EN.
module ch3_wave_sequencer #(
   parameter int FREQ_W = 11,
   parameter int POS_W  = 5,
   parameter int LEN_W  = 8
) (
   input  logic              amuk_4mhz,
   input  logic              apu_reset,
   input  logic              tick_2mhz,
   input  logic              dac_en,
   input  logic              trigger,
   input  logic [FREQ_W-1:0] freq,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [POS_W-2:0]  cpu_addr,
   input  logic [7:0]        cpu_wdata,
   output logic [7:0]        cpu_rdata,
   output logic              cpu_ack,
   output logic [POS_W-2:0]  wram_addr,
   output logic              wram_rd,
   output logic              wram_wr,
   output logic [7:0]        wram_wdata,
   input  logic [7:0]        wram_rdata,
   output logic [3:0]        wave_play_d,
   output logic              ch3_active,
   input  logic              len_tick,
   input  logic              len_en,
   input  logic [LEN_W-1:0]  len_load,
   input  logic              len_wr
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [FREQ_W-1:0] counter;
   logic [POS_W-1:0]  pos;
   logic [POS_W-1:0]  pos_inc;
   logic [7:0]        sample_buf;
   logic              play_lo;
   logic              run;
   logic              overflow;
   logic              fetch;
   logic              fetch_q;
   logic              wr_pend;
   logic [7:0]        wr_pend_dat;
   logic              ack_ram;
   logic              len_expire;

   assign run      = (state == ST_RUN);
   assign overflow = run && tick_2mhz && (counter == '1);
   // A trigger in the same cycle reloads instead, so the step and its fetch are lost.
   assign fetch    = overflow && !trigger;
   assign pos_inc  = pos + POS_W'(1);

   assign ch3_active  = run;
   assign wave_play_d = play_lo ? sample_buf[3:0] : sample_buf[7:4];
   assign cpu_rdata   = ack_ram ? wram_rdata : 8'hFF;

`ifdef CH3_LENGTH_EN
   logic [LEN_W-1:0] len_cnt;
   logic             len_step;

   assign len_step   = run && len_tick && len_en && !len_wr;
   assign len_expire = len_step && (len_cnt == '1);

   // Trigger leaves the length counter untouched, so a zero count stays zero.
   always_ff @(posedge amuk_4mhz or posedge apu_reset) begin
      if (apu_reset) begin
         len_cnt <= '0;
      end else if (len_wr) begin
         len_cnt <= len_load;
      end else if (len_step) begin
         len_cnt <= len_cnt + LEN_W'(1);
      end
   end
`else
   logic unused_len;
   assign unused_len = ^{len_tick, len_en, len_load, len_wr};
   assign len_expire = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      if (trigger && dac_en) begin
         state_nxt = ST_RUN;
      end else if (!dac_en || len_expire) begin
         state_nxt = ST_IDLE;
      end
   end

   // While running, the CPU only ever sees the byte under the play position.
   always_comb begin
      wram_rd    = 1'b0;
      wram_wr    = 1'b0;
      wram_addr  = pos[POS_W-1:1];
      wram_wdata = cpu_wdata;
      if (fetch) begin
         wram_rd   = 1'b1;
         wram_addr = pos_inc[POS_W-1:1];
      end else if (run && wr_pend) begin
         wram_wr    = 1'b1;
         wram_wdata = wr_pend_dat;
      end else if (!run && cpu_req) begin
         wram_addr = cpu_addr;
         wram_rd   = !cpu_wr;
         wram_wr   = cpu_wr;
      end
   end

   always_ff @(posedge amuk_4mhz or posedge apu_reset) begin
      if (apu_reset) begin
         state       <= ST_IDLE;
         counter     <= '0;
         pos         <= '0;
         sample_buf  <= 8'h00;
         play_lo     <= 1'b0;
         fetch_q     <= 1'b0;
         wr_pend     <= 1'b0;
         wr_pend_dat <= 8'h00;
         cpu_ack     <= 1'b0;
         ack_ram     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cpu_ack <= cpu_req;
         ack_ram <= cpu_req && !cpu_wr && (!run || fetch);
         fetch_q <= fetch;
         // A CPU write colliding with a fetch lands on the fetched byte in the following cycle.
         wr_pend <= fetch && cpu_req && cpu_wr;
         if (fetch && cpu_req && cpu_wr) begin
            wr_pend_dat <= cpu_wdata;
         end
         if (trigger) begin
            counter <= freq;
            pos     <= '0;
         end else if (run && tick_2mhz) begin
            if (overflow) begin
               counter <= freq;
               pos     <= pos_inc;
            end else begin
               counter <= counter + FREQ_W'(1);
            end
         end
         if (fetch_q) begin
            sample_buf <= wram_rdata;
            play_lo    <= pos[0];
         end
      end
   end

endmodule

// File: tb/tb_ch3_wave_sequencer.sv
// Scoreboard bench for ch3_wave_sequencer: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_ch3_wave_sequencer;

   typedef struct {
      logic       rd;
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic       play;
   } strobe_t;

   typedef struct {
      logic       is_rd;
      logic [7:0] data;
   } ack_t;

   logic        amuk_4mhz = 1'b0;
   logic        apu_reset = 1'b0;
   logic        tick_2mhz = 1'b0;
   logic        dac_en    = 1'b0;
   logic        trigger   = 1'b0;
   logic [10:0] freq      = 11'h000;
   logic        cpu_req   = 1'b0;
   logic        cpu_wr    = 1'b0;
   logic [3:0]  cpu_addr  = 4'h0;
   logic [7:0]  cpu_wdata = 8'h00;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack;
   logic [3:0]  wram_addr;
   logic        wram_rd;
   logic        wram_wr;
   logic [7:0]  wram_wdata;
   logic [7:0]  wram_rdata = 8'h00;
   logic [3:0]  wave_play_d;
   logic        ch3_active;
   logic        len_tick  = 1'b0;
   logic        len_en    = 1'b0;
   logic [7:0]  len_load  = 8'h00;
   logic        len_wr    = 1'b0;

   logic [7:0] mem [16] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0,
                            8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

   strobe_t    exp_strobe[$];
   ack_t       exp_ack[$];
   logic [3:0] exp_play[$];

   int total = 0;
   int bad   = 0;

   ch3_wave_sequencer dut (
      .amuk_4mhz  (amuk_4mhz),
      .apu_reset  (apu_reset),
      .tick_2mhz  (tick_2mhz),
      .dac_en     (dac_en),
      .trigger    (trigger),
      .freq       (freq),
      .cpu_req    (cpu_req),
      .cpu_wr     (cpu_wr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ack    (cpu_ack),
      .wram_addr  (wram_addr),
      .wram_rd    (wram_rd),
      .wram_wr    (wram_wr),
      .wram_wdata (wram_wdata),
      .wram_rdata (wram_rdata),
      .wave_play_d(wave_play_d),
      .ch3_active (ch3_active),
      .len_tick   (len_tick),
      .len_en     (len_en),
      .len_load   (len_load),
      .len_wr     (len_wr)
   );

   always #5 amuk_4mhz = ~amuk_4mhz;

   always @(posedge amuk_4mhz) begin
      if (wram_wr) mem[wram_addr] <= wram_wdata;
      if (wram_rd) wram_rdata <= mem[wram_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_fetch(input int p, input logic with_play);
      strobe_t    e;
      logic [4:0] np;
      np      = 5'(p);
      e.rd    = 1'b1;
      e.wr    = 1'b0;
      e.addr  = np[4:1];
      e.wdata = 8'h00;
      e.play  = with_play;
      exp_strobe.push_back(e);
      if (with_play) exp_play.push_back(4'(np + 5'd1));
   endtask

   task automatic push_cpu(input logic rd, input logic [3:0] addr, input logic [7:0] wdata);
      strobe_t e;
      e.rd    = rd;
      e.wr    = !rd;
      e.addr  = addr;
      e.wdata = wdata;
      e.play  = 1'b0;
      exp_strobe.push_back(e);
   endtask

   task automatic push_ack(input logic is_rd, input logic [7:0] data);
      ack_t a;
      a.is_rd = is_rd;
      a.data  = data;
      exp_ack.push_back(a);
   endtask

   task automatic cyc();
      @(posedge amuk_4mhz);
      #1;
      trigger   = 1'b0;
      cpu_req   = 1'b0;
      tick_2mhz = 1'b0;
      len_tick  = 1'b0;
      len_wr    = 1'b0;
   endtask

   // Monitor: strobes, acks and the sample two cycles after each playback fetch.
   initial begin
      logic       play_d1;
      logic       play_d2;
      logic [3:0] last_play;
      strobe_t    e;
      ack_t       a;
      logic [3:0] ep;
      play_d1   = 1'b0;
      play_d2   = 1'b0;
      last_play = 4'h0;
      forever begin
         @(negedge amuk_4mhz);
         if (apu_reset) begin
            play_d1   = 1'b0;
            play_d2   = 1'b0;
            last_play = 4'h0;
         end else begin
            if (play_d2) begin
               if (exp_play.size() == 0) begin
                  chk("play_unexpected", 32'(wave_play_d), 32'hFFFF);
               end else begin
                  ep = exp_play.pop_front();
                  chk("play_nibble", 32'(wave_play_d), 32'(ep));
                  last_play = ep;
               end
            end
            if (play_d1) chk("play_hold", 32'(wave_play_d), 32'(last_play));
            play_d2 = play_d1;
            play_d1 = 1'b0;
            if (wram_rd || wram_wr) begin
               if (exp_strobe.size() == 0) begin
                  chk("unexpected_strobe", 32'({wram_rd, wram_wr}), 32'h0);
               end else begin
                  e = exp_strobe.pop_front();
                  chk("strobe_kind", 32'({wram_rd, wram_wr}), 32'({e.rd, e.wr}));
                  chk("strobe_addr", 32'(wram_addr), 32'(e.addr));
                  if (e.wr) chk("strobe_wdata", 32'(wram_wdata), 32'(e.wdata));
                  play_d1 = e.play;
               end
            end
            if (cpu_ack) begin
               if (exp_ack.size() == 0) begin
                  chk("unexpected_ack", 32'(cpu_ack), 32'h0);
               end else begin
                  a = exp_ack.pop_front();
                  if (a.is_rd) chk("cpu_rdata", 32'(cpu_rdata), 32'(a.data));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      apu_reset = 1'b1;
      #1;
      chk("rst_rdata", 32'(cpu_rdata), 32'hFF);
      chk("rst_ack", 32'(cpu_ack), 32'h0);
      chk("rst_addr", 32'(wram_addr), 32'h0);
      chk("rst_strobes", 32'({wram_rd, wram_wr}), 32'h0);
      chk("rst_wave", 32'(wave_play_d), 32'h0);
      chk("rst_active", 32'(ch3_active), 32'h0);
      @(posedge amuk_4mhz);
      #1;
      apu_reset = 1'b0;
      cyc();

      // Full sweep: freq 0x7FE overflows every second tick, pos 1..31 then wraps to 0.
      dac_en = 1'b1; freq = 11'h7FE; trigger = 1'b1;
      cyc();
      chk("trig_active", 32'(ch3_active), 32'h1);
      for (int p = 1; p <= 32; p++) push_fetch(p, 1'b1);
      for (int t = 0; t < 64; t++) begin
         tick_2mhz = 1'b1;
         cyc();
         cyc();
      end

      // Advance to pos 6; CPU read on that fetch cycle returns byte 3.
      for (int p = 1; p <= 6; p++) push_fetch(p, 1'b1);
      for (int t = 1; t <= 12; t++) begin
         tick_2mhz = 1'b1;
         if (t == 12) begin
            cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'hC;
            push_ack(1'b1, 8'h78);
         end
         cyc();
         cyc();
      end

      // Off-fetch CPU accesses while running: read gives 0xFF, write is dropped.
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'h0;
      push_ack(1'b1, 8'hFF);
      #1;
      chk("run_addr_forced", 32'(wram_addr), 32'h3);
      cyc();
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 4'h5; cpu_wdata = 8'h3C;
      push_ack(1'b0, 8'h00);
      cyc();

      // Trigger coinciding with an overflow: no fetch, pos 0, counter reloaded with new freq.
      tick_2mhz = 1'b1;
      cyc();
      cyc();
      tick_2mhz = 1'b1; trigger = 1'b1; freq = 11'h7FC;
      cyc();
      chk("trig_hold_sample", 32'(wave_play_d), 32'h7);
      push_fetch(1, 1'b1);
      for (int t = 1; t <= 3; t++) begin
         tick_2mhz = 1'b1;
         cyc();
         cyc();
      end
      chk("reload_not_early", 32'(exp_strobe.size()), 32'h1);
      tick_2mhz = 1'b1;
      cyc();
      chk("reload_fetch", 32'(exp_strobe.size()), 32'h0);
      dac_en = 1'b0;
      cyc();
      chk("dac_off_idle", 32'(ch3_active), 32'h0);
      cyc();
      cyc();
      trigger = 1'b1;
      cyc();
      chk("trig_no_dac", 32'(ch3_active), 32'h0);

      // Length: 0xFE plus two ticks wraps to 0x00.
      dac_en = 1'b1; trigger = 1'b1; freq = 11'h7FE;
      cyc();
      len_load = 8'hFE; len_wr = 1'b1;
      cyc();
      len_en = 1'b1; len_tick = 1'b1;
      cyc();
      chk("len_one_tick", 32'(ch3_active), 32'h1);
      len_tick = 1'b1;
      cyc();
`ifdef CH3_LENGTH_EN
      chk("len_expire", 32'(ch3_active), 32'h0);
`else
      chk("len_ignored", 32'(ch3_active), 32'h1);
`endif
      len_en = 1'b0; dac_en = 1'b0;
      cyc();
      chk("idle_again", 32'(ch3_active), 32'h0);

      // Idle CPU path: write then read back, plus untouched bytes at both ends.
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 4'h3; cpu_wdata = 8'hA5;
      push_cpu(1'b0, 4'h3, 8'hA5); push_ack(1'b0, 8'h00);
      cyc();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'h3;
      push_cpu(1'b1, 4'h3, 8'h00); push_ack(1'b1, 8'hA5);
      cyc();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'h5;
      push_cpu(1'b1, 4'h5, 8'h00); push_ack(1'b1, 8'hBC);
      cyc();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'h0;
      push_cpu(1'b1, 4'h0, 8'h00); push_ack(1'b1, 8'h12);
      cyc();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'hF;
      push_cpu(1'b1, 4'hF, 8'h00); push_ack(1'b1, 8'hF0);
      cyc();
      cyc();
      cyc();

      // Reset mid-run right after a fetch that collided with a CPU write.
      dac_en = 1'b1; freq = 11'h7FE; trigger = 1'b1;
      cyc();
      tick_2mhz = 1'b1;
      cyc();
      cyc();
      push_fetch(1, 1'b0);
      tick_2mhz = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 4'h2; cpu_wdata = 8'h66;
      cyc();
      apu_reset = 1'b1;
      #1;
      chk("midrst_strobes", 32'({wram_rd, wram_wr}), 32'h0);
      chk("midrst_active", 32'(ch3_active), 32'h0);
      chk("midrst_ack", 32'(cpu_ack), 32'h0);
      chk("midrst_rdata", 32'(cpu_rdata), 32'hFF);
      chk("midrst_addr", 32'(wram_addr), 32'h0);
      chk("midrst_wave", 32'(wave_play_d), 32'h0);
      cyc();
      cyc();
      apu_reset = 1'b0;
      cyc();
      cyc();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 4'h0;
      push_cpu(1'b1, 4'h0, 8'h00); push_ack(1'b1, 8'h12);
      cyc();
      dac_en = 1'b0;
      cyc();
      cyc();
      cyc();

      chk("strobe_q_empty", 32'(exp_strobe.size()), 32'h0);
      chk("ack_q_empty", 32'(exp_ack.size()), 32'h0);
      chk("play_q_empty", 32'(exp_play.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
